// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter for NREQ functional units.
// Each unit owns a one-entry hold buffer; a live result may bypass it.
module wb_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int ROBW = 3,
   parameter int RDW  = 7,
   localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ*ROBW-1:0] req_rob_idx,
   input  logic [NREQ*RDW-1:0]  req_rd,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 flush,
   output logic                 wb_valid,
   output logic [DW-1:0]        wb_data,
   output logic [ROBW-1:0]      wb_rob_idx,
   output logic [RDW-1:0]       wb_rd,
   output logic [SW-1:0]        wb_src
);

   logic [NREQ-1:0] held_q, held_d, cand, cap;
   logic [DW-1:0]   data_q [NREQ];
   logic [ROBW-1:0] rob_q  [NREQ];
   logic [RDW-1:0]  rd_q   [NREQ];
   logic [SW-1:0]   ptr_q, ptr_d;

   logic            gnt;
   logic [SW-1:0]   g;
   int              idx;
   logic [DW-1:0]   sel_data;
   logic [ROBW-1:0] sel_rob;
   logic [RDW-1:0]  sel_rd;

   assign req_ready = ~held_q;
   assign cand      = held_q | req_valid;

   // Scan downward so the candidate nearest ptr is the last one written.
   always_comb begin
      gnt = 1'b0;
      g   = '0;
      idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (cand[idx]) begin
            gnt = 1'b1;
            g   = SW'(idx);
         end
      end
   end

   always_comb begin
      if (held_q[g]) begin
         sel_data = data_q[g];
         sel_rob  = rob_q[g];
         sel_rd   = rd_q[g];
      end else begin
         sel_data = req_data[g*DW +: DW];
         sel_rob  = req_rob_idx[g*ROBW +: ROBW];
         sel_rd   = req_rd[g*RDW +: RDW];
      end
   end

   always_comb begin
      held_d = held_q;
      cap    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt && int'(g) == i) begin
            held_d[i] = 1'b0;
         end else if (!held_q[i] && req_valid[i]) begin
            held_d[i] = 1'b1;
            cap[i]    = 1'b1;
         end
         if (flush) held_d[i] = 1'b0;
      end
      ptr_d = ptr_q;
      if (gnt && !flush) ptr_d = SW'((int'(g) + 1) % NREQ);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         held_q     <= '0;
         ptr_q      <= '0;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rob_idx <= '0;
         wb_rd      <= '0;
         wb_src     <= '0;
         for (int i = 0; i < NREQ; i++) begin
            data_q[i] <= '0;
            rob_q[i]  <= '0;
            rd_q[i]   <= '0;
         end
      end else begin
         held_q <= held_d;
         ptr_q  <= ptr_d;
         for (int i = 0; i < NREQ; i++) begin
            if (cap[i] && !flush) begin
               data_q[i] <= req_data[i*DW +: DW];
               rob_q[i]  <= req_rob_idx[i*ROBW +: ROBW];
               rd_q[i]   <= req_rd[i*RDW +: RDW];
            end
         end
         if (gnt && !flush) begin
            wb_valid   <= 1'b1;
            wb_data    <= sel_data;
            wb_rob_idx <= sel_rob;
            wb_rd      <= sel_rd;
            wb_src     <= g;
         end else begin
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rob_idx <= '0;
            wb_rd      <= '0;
            wb_src     <= '0;
         end
      end
   end

endmodule
